// File: rtl/jtag_bridge_pkg.sv
// jtag_bridge_pkg: shared definitions for the JTAG UART stream bridge.
//   DATA_REG / CTRL_REG : JTAG UART register addresses (av_address)
//   RVALID_BIT          : data-register bit flagging a valid received byte
//   WSPACE_LSB          : LSB of the 16-bit write-space field in the control register
//   state_t             : Avalon master FSM states
package jtag_bridge_pkg;

  localparam logic        DATA_REG   = 1'b0;
  localparam logic        CTRL_REG   = 1'b1;
  localparam int unsigned RVALID_BIT = 15;
  localparam int unsigned WSPACE_LSB = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RX_POLL  = 2'd1,
    ST_TX_SPACE = 2'd2,
    ST_TX_WRITE = 2'd3
  } state_t;

endpackage

// File: rtl/jtag_bridge_fifo.sv
// jtag_bridge_fifo: synchronous show-ahead FIFO with level output.
//   i_clk, i_rst_n : clock, async active-low reset (clears pointers/level)
//   i_push, i_data : write request / data (ignored when full)
//   i_pop          : read request (ignored when empty)
//   o_data         : head word
//   o_full, o_empty, o_level : occupancy status
module jtag_bridge_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_data  = r_mem[r_rd];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/jtag_stream_bridge.sv
// jtag_stream_bridge: user word streams <-> JTAG UART bytes over Avalon-MM, LSB first.
//   clk_clk, reset_reset_n          : clock, async active-low reset
//   tx_valid/tx_ready/tx_data       : user TX word stream into the TX FIFO
//   rx_valid/rx_ready/rx_data/rx_bytes : RX FIFO head word and its valid byte count
//   av_*                            : Avalon-MM master to the JTAG UART slave
// Optional feature: define JTAG_BRIDGE_RX_FLUSH_EN to flush a partial RX word
// after RX_TIMEOUT cycles without a received byte.
module jtag_stream_bridge
  import jtag_bridge_pkg::*;
#(
  parameter int unsigned WORD_BYTES = 2,
  parameter int unsigned TX_DEPTH   = 16,
  parameter int unsigned RX_DEPTH   = 16,
  parameter int unsigned RX_TIMEOUT = 1024
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  input  logic [8*WORD_BYTES-1:0] tx_data,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic [8*WORD_BYTES-1:0] rx_data,
  output logic [2:0]              rx_bytes,
  output logic                    av_chipselect,
  output logic                    av_address,
  output logic                    av_read_n,
  output logic                    av_write_n,
  output logic [31:0]             av_writedata,
  input  logic [31:0]             av_readdata,
  input  logic                    av_waitrequest
);

  localparam int unsigned DW = 8*WORD_BYTES;

  state_t          r_state, w_next;
  logic [15:0]     r_tx_credit;
  logic            r_last_tx;
  logic            r_tx_en;
  logic [DW-1:0]   r_tx_word;
  logic [2:0]      r_tx_left;
  logic [DW-1:0]   r_pk_data;
  logic [2:0]      r_pk_cnt;

  logic            w_done, w_rx_byte, w_pk_full, w_flush, w_rx_elig, w_tx_pend;
  logic [DW-1:0]   w_pk_word;
  logic            w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
  logic [DW-1:0]   w_tx_dout;
  logic            w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
  logic [DW+2:0]   w_rx_din, w_rx_dout;
  logic [$clog2(TX_DEPTH):0] w_tx_level;
  logic [$clog2(RX_DEPTH):0] w_rx_level;
  logic            w_unused;

  assign w_unused = ^{av_readdata[14:8], w_tx_level, w_rx_level};

  // Transfer handshake and packer datapath
  assign w_done    = (r_state != ST_IDLE) && !av_waitrequest;
  assign w_rx_byte = w_done && (r_state == ST_RX_POLL) && av_readdata[RVALID_BIT];
  assign w_pk_word = r_pk_data | (DW'(av_readdata[7:0]) << {r_pk_cnt, 3'b000});
  assign w_pk_full = w_rx_byte && (r_pk_cnt == 3'(WORD_BYTES-1));
  assign w_tx_pend = (r_tx_left != '0);

`ifdef JTAG_BRIDGE_RX_FLUSH_EN
  logic [31:0] r_to_cnt;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)                     r_to_cnt <= '0;
    else if (w_rx_byte || r_pk_cnt == '0)   r_to_cnt <= '0;
    else if (r_to_cnt < 32'(RX_TIMEOUT-1))  r_to_cnt <= r_to_cnt + 32'd1;
  end

  // Flush never overlaps an RX_POLL, so a poll started on a non-full FIFO
  // always has room for the word it may complete.
  assign w_flush = (r_pk_cnt != '0) && (r_to_cnt >= 32'(RX_TIMEOUT-1)) &&
                   (r_state != ST_RX_POLL) && !w_rx_full;
`else
  assign w_flush = 1'b0;
`endif

  assign w_rx_elig = !w_rx_full && !w_flush;
  assign w_rx_push = w_pk_full || w_flush;
  assign w_rx_din  = w_flush ? {r_pk_cnt, r_pk_data} : {3'(WORD_BYTES), w_pk_word};
  assign w_rx_pop  = rx_valid && rx_ready;
  assign w_tx_push = tx_valid && tx_ready;
  assign w_tx_pop  = !w_tx_pend && !w_tx_empty;

  assign tx_ready  = r_tx_en && !w_tx_full;
  assign rx_valid  = !w_rx_empty;
  assign rx_data   = rx_valid ? w_rx_dout[DW-1:0] : '0;
  assign rx_bytes  = rx_valid ? w_rx_dout[DW+:3]  : '0;

  jtag_bridge_fifo #(.WIDTH(DW), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .i_clk(clk_clk), .i_rst_n(reset_reset_n),
    .i_push(w_tx_push), .i_data(tx_data), .i_pop(w_tx_pop),
    .o_data(w_tx_dout), .o_full(w_tx_full), .o_empty(w_tx_empty), .o_level(w_tx_level)
  );

  jtag_bridge_fifo #(.WIDTH(DW+3), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .i_clk(clk_clk), .i_rst_n(reset_reset_n),
    .i_push(w_rx_push), .i_data(w_rx_din), .i_pop(w_rx_pop),
    .o_data(w_rx_dout), .o_full(w_rx_full), .o_empty(w_rx_empty), .o_level(w_rx_level)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_state <= ST_IDLE;
    else                r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    av_chipselect = 1'b0;
    av_address    = DATA_REG;
    av_read_n     = 1'b1;
    av_write_n    = 1'b1;
    av_writedata  = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_tx_pend && (r_last_tx || !w_rx_elig) && w_rx_elig)
          w_next = ST_RX_POLL;
        else if (w_tx_pend)
          w_next = (r_tx_credit != '0) ? ST_TX_WRITE : ST_TX_SPACE;
        else if (w_rx_elig)
          w_next = ST_RX_POLL;
      end
      ST_RX_POLL: begin
        av_chipselect = 1'b1;
        av_read_n     = 1'b0;
        if (w_done) w_next = ST_IDLE;
      end
      ST_TX_SPACE: begin
        av_chipselect = 1'b1;
        av_address    = CTRL_REG;
        av_read_n     = 1'b0;
        if (w_done) w_next = ST_IDLE;
      end
      ST_TX_WRITE: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_writedata  = {24'h0, r_tx_word[7:0]};
        if (w_done) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_tx_en     <= 1'b0;
      r_last_tx   <= 1'b0;
      r_tx_credit <= '0;
      r_tx_word   <= '0;
      r_tx_left   <= '0;
      r_pk_data   <= '0;
      r_pk_cnt    <= '0;
    end else begin
      r_tx_en <= 1'b1;
      if (r_state == ST_IDLE && w_next != ST_IDLE)
        r_last_tx <= (w_next != ST_RX_POLL);

      if (w_done && r_state == ST_TX_SPACE)
        r_tx_credit <= av_readdata[WSPACE_LSB +: 16];
      else if (w_done && r_state == ST_TX_WRITE)
        r_tx_credit <= r_tx_credit - 16'd1;

      if (w_tx_pop) begin
        r_tx_word <= w_tx_dout;
        r_tx_left <= 3'(WORD_BYTES);
      end else if (w_done && r_state == ST_TX_WRITE) begin
        r_tx_word <= r_tx_word >> 8;
        r_tx_left <= r_tx_left - 3'd1;
      end

      if (w_rx_push) begin
        r_pk_data <= '0;
        r_pk_cnt  <= '0;
      end else if (w_rx_byte) begin
        r_pk_data <= w_pk_word;
        r_pk_cnt  <= r_pk_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_jtag_stream_bridge.sv
// tb_jtag_stream_bridge: scoreboard bench for jtag_stream_bridge (WORD_BYTES=2).
// A negedge slave/monitor models the JTAG UART and pops expected writes/RX words.
module tb_jtag_stream_bridge;

  localparam int unsigned WB = 2;
`ifdef JTAG_BRIDGE_RX_FLUSH_EN
  localparam int unsigned TOUT = 8;
`else
  localparam int unsigned TOUT = 1024;
`endif

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;
  logic [15:0] tx_data, rx_data;
  logic [2:0]  rx_bytes;
  logic        av_chipselect, av_address, av_read_n, av_write_n;
  logic [31:0] av_writedata;
  logic [31:0] av_readdata = '0;
  logic        av_waitrequest = 1'b0;

  always #5 clk_clk = ~clk_clk;

  jtag_stream_bridge #(.WORD_BYTES(WB), .TX_DEPTH(16), .RX_DEPTH(16), .RX_TIMEOUT(TOUT)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_bytes(rx_bytes),
    .av_chipselect(av_chipselect), .av_address(av_address), .av_read_n(av_read_n),
    .av_write_n(av_write_n), .av_writedata(av_writedata), .av_readdata(av_readdata),
    .av_waitrequest(av_waitrequest)
  );

  int n_tests = 0, n_fail = 0;
  logic [7:0]  exp_wr[$];
  logic [18:0] exp_rx[$];
  logic [31:0] rx_reply[$];
  logic [15:0] wspace = 16'd64;
  int n_wr = 0, n_ctrl = 0, n_rd0 = 0, rv_cnt = 0;
  int stall_cfg = 0, stall_req_id = 0, stall_seen_id = 0, stall_left = 0, stall_seen = 0;
  bit stalling = 0, lat_check = 0, lat_due = 0;
  logic [34:0] snap, cur;
  logic [31:0] r;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bad(input string name, input logic [63:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %0h expected none", name, act);
  endtask

  function automatic int qsize(input int which);
    case (which)
      0:       return exp_wr.size();
      1:       return exp_rx.size();
      default: return rx_reply.size();
    endcase
  endfunction

  task automatic wait_q(input int which, input int max_cyc, input string name);
    for (int i = 0; i < max_cyc; i++) begin
      if (qsize(which) == 0) break;
      @(posedge clk_clk); #1;
    end
    chk(name, qsize(which), 0);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  task automatic push_tx(input logic [15:0] w);
    bit rdy = 0;
    bit done = 0;
    tx_data  = w;
    tx_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk_clk); rdy = tx_ready;
      @(posedge clk_clk); #1;
      done = rdy;
    end
    tx_valid = 1'b0;
    chk("tx push accepted", done, 1);
  endtask

  // Slave model and scoreboard monitor
  always @(negedge clk_clk) begin
    if (lat_due) begin
      chk("rx_valid latency", rx_valid, 1);
      lat_due = 0;
    end
    if (rx_valid && rx_ready) begin
      if (exp_rx.size() == 0) bad("rx word", {rx_bytes, rx_data});
      else chk("rx word", {rx_bytes, rx_data}, exp_rx.pop_front());
    end
    av_waitrequest = 1'b0;
    av_readdata    = '0;
    if (!reset_reset_n) begin
      stall_left = 0;
      stalling   = 0;
    end else if (av_chipselect) begin
      if (!av_write_n) begin
        if (!stalling && stall_seen_id != stall_req_id) begin
          stall_left    = stall_cfg;
          stall_seen_id = stall_req_id;
        end
        cur = {av_address, av_read_n, av_write_n, av_writedata};
        if (stall_left > 0) begin
          if (stalling) chk("write hold", cur, snap);
          else snap = cur;
          stalling = 1;
          stall_left--;
          stall_seen++;
          av_waitrequest = 1'b1;
        end else begin
          if (stalling) chk("write hold", cur, snap);
          stalling = 0;
          n_wr++;
          if (exp_wr.size() == 0) bad("write byte", av_writedata);
          else chk("write byte", av_writedata, {24'h0, exp_wr.pop_front()});
        end
      end else if (!av_read_n) begin
        if (av_address) begin
          n_ctrl++;
          av_readdata = {wspace, 16'h0};
        end else begin
          n_rd0++;
          if (rx_reply.size() != 0) begin
            r = rx_reply.pop_front();
            av_readdata = r;
            if (r[15]) begin
              rv_cnt++;
              if (lat_check && (rv_cnt % WB) == 0) begin
                chk("rx_valid before word", rx_valid, 0);
                lat_due = 1;
              end
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, w0, s0, r0;
    reset_reset_n = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    rx_ready = 1'b0;
    cycles(3);
    chk("reset avalon", {av_chipselect, av_address, av_read_n, av_write_n, av_writedata},
        {1'b0, 1'b0, 1'b1, 1'b1, 32'h0});
    chk("reset user", {tx_ready, rx_valid, rx_bytes, rx_data}, 0);
    reset_reset_n = 1'b1;
    chk("tx_ready before first edge", tx_ready, 0);
    cycles(1);
    chk("tx_ready after first edge", tx_ready, 1);

    // TX path: one CTRL read then EF, BE
    c0 = n_ctrl;
    exp_wr.push_back(8'hEF);
    exp_wr.push_back(8'hBE);
    push_tx(16'hBEEF);
    wait_q(0, 200, "tx drain");
    cycles(4);
    chk("ctrl reads", n_ctrl - c0, 1);
    chk("write count", n_wr, 2);
    chk("tx_credit", dut.r_tx_credit, 62);

    // Waitrequest held 5 cycles during a write
    stall_cfg = 5;
    stall_req_id++;
    s0 = stall_seen;
    exp_wr.push_back(8'h34);
    exp_wr.push_back(8'h12);
    push_tx(16'h1234);
    wait_q(0, 200, "stall drain");
    cycles(4);
    chk("stall cycles", stall_seen - s0, 5);
    chk("write count after stall", n_wr, 4);
    chk("tx_credit after stall", dut.r_tx_credit, 60);

    // Reset during a stalled write
    stall_cfg = 100;
    stall_req_id++;
    s0 = stall_seen;
    w0 = n_wr;
    push_tx(16'hCAFE);
    for (int i = 0; i < 100 && (stall_seen - s0) < 3; i++) cycles(1);
    chk("stalled cycles before reset", (stall_seen - s0) >= 3, 1);
    reset_reset_n = 1'b0;
    #1;
    chk("async reset avalon", {av_chipselect, av_address, av_read_n, av_write_n, av_writedata},
        {1'b0, 1'b0, 1'b1, 1'b1, 32'h0});
    chk("async reset user", {tx_ready, rx_valid, rx_bytes, rx_data}, 0);
    cycles(2);
    reset_reset_n = 1'b1;
    chk("release avalon", {av_chipselect, av_address, av_read_n, av_write_n, av_writedata},
        {1'b0, 1'b0, 1'b1, 1'b1, 32'h0});
    chk("fifo levels after reset", {dut.u_tx_fifo.r_level, dut.u_rx_fifo.r_level}, 0);
    chk("tx_ready at release", tx_ready, 0);
    cycles(1);
    chk("tx_ready first edge after reset", tx_ready, 1);
    cycles(20);
    chk("no replayed write", n_wr, w0);
    chk("tx_credit cleared", dut.r_tx_credit, 0);

    // RX path: 41, (no byte), 42 -> 16'h4241
    lat_check = 1;
    rx_reply.push_back(32'h0000_8041);
    rx_reply.push_back(32'h0000_0000);
    rx_reply.push_back(32'h0000_8042);
    exp_rx.push_back({3'd2, 16'h4241});
    wait_q(2, 100, "rx replies consumed");
    cycles(3);
    lat_check = 0;
    chk("rx level one word", dut.u_rx_fifo.r_level, 1);
    rx_ready = 1'b1;
    wait_q(1, 50, "rx drain");
    cycles(3);
    chk("rx_valid after drain", rx_valid, 0);

    // RX FIFO full: polling stops
    rx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] lo, hi;
      lo = 8'(8'h10 + 2*i);
      hi = 8'(8'h11 + 2*i);
      rx_reply.push_back({16'h0, 8'h80, lo});
      rx_reply.push_back({16'h0, 8'h80, hi});
      exp_rx.push_back({3'd2, hi, lo});
    end
    wait_q(2, 400, "rx fill replies consumed");
    cycles(5);
    r0 = n_rd0;
    cycles(40);
    chk("no poll while rx full", n_rd0 - r0, 0);
    chk("rx level full", dut.u_rx_fifo.r_level, 16);
    rx_ready = 1'b1;
    wait_q(1, 100, "rx full drain");

    // WSPACE = 0: repeated CTRL reads, no writes
    wspace = 16'd0;
    c0 = n_ctrl;
    w0 = n_wr;
    push_tx(16'h7788);
    cycles(60);
    chk("repeated ctrl reads", (n_ctrl - c0) >= 3, 1);
    chk("no write at wspace 0", n_wr - w0, 0);
    exp_wr.push_back(8'h88);
    exp_wr.push_back(8'h77);
    wspace = 16'd4;
    wait_q(0, 100, "tx drain after wspace");
    cycles(4);
    chk("tx_credit after wspace 4", dut.r_tx_credit, 2);

`ifdef JTAG_BRIDGE_RX_FLUSH_EN
    exp_rx.push_back({3'd1, 16'h005A});
    rx_reply.push_back(32'h0000_805A);
    wait_q(2, 100, "flush reply consumed");
    cycles(5);
    chk("no early flush", exp_rx.size(), 1);
    wait_q(1, 100, "flush word");
`else
    rx_reply.push_back(32'h0000_8033);
    wait_q(2, 100, "partial reply consumed");
    cycles(100);
    chk("partial word held", rx_valid, 0);
`endif

    cycles(4);
    chk("leftover writes", exp_wr.size(), 0);
    chk("leftover rx words", exp_rx.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
